// File: rtl/write_out_pkg.sv
// Shared types and sizing helpers for the PE-row to SRAM write serializer.
package write_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ROW = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    function automatic int beats_of(input int array_size, input int lanes);
        return array_size / lanes;
    endfunction

    // A single-beat row still needs a one-bit counter.
    function automatic int beat_cnt_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    function automatic bit lanes_divide(input int array_size, input int lanes);
        return (lanes > 0) && (array_size % lanes == 0);
    endfunction

endpackage

// File: rtl/write_out_beat_sel.sv
// Registered lane-slice mux: picks LANES words of a row by beat index.
module write_out_beat_sel #(
    parameter int ARRAY_SIZE = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int BCW        = 5
) (
    input  logic                             clk,
    input  logic                             srstn,
    input  logic                             load,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] row,
    input  logic [BCW-1:0]                   beat,
    output logic [LANES*DATA_WIDTH-1:0]      wdata
);

    localparam int SLICE_W = LANES * DATA_WIDTH;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            wdata <= '0;
        end else if (load) begin
            wdata <= row[int'(beat) * SLICE_W +: SLICE_W];
        end
    end

endmodule

// File: rtl/write_out_stream.sv
// Buffers one PE result row and drains it to the result SRAM LANES words per beat.
//   state    | meaning
//   IDLE     | waiting for cfg_start; no writes
//   WAIT_ROW | run active, buffer empty, in_ready high
//   DRAIN    | buffered row being written, one beat per accepted sram_ready
module write_out_stream
    import write_out_pkg::*;
#(
    parameter int ARRAY_SIZE    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LANES         = 1,
    parameter int ADDR_WIDTH    = 10,
    parameter int ROW_CNT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             srstn,
    input  logic                             cfg_start,
    input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
    input  logic [ROW_CNT_WIDTH-1:0]         cfg_num_rows,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] parallel_data_in,
    input  logic                             sram_ready,
    output logic                             sram_we,
    output logic [LANES*DATA_WIDTH-1:0]      sram_wdata,
    output logic [ADDR_WIDTH-1:0]            sram_waddr,
    output logic                             busy,
    output logic                             done
);

    localparam int BEATS = beats_of(ARRAY_SIZE, LANES);
    localparam int BCW   = beat_cnt_width(BEATS);
    localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    if (!lanes_divide(ARRAY_SIZE, LANES)) begin : g_bad_lanes
        $error("write_out_stream: LANES must divide ARRAY_SIZE");
    end

    state_t                   state, state_nxt;
    logic [ROW_W-1:0]         row_buf;
    logic [ROW_CNT_WIDTH-1:0] num_rows_q;
    logic [ROW_CNT_WIDTH-1:0] row_cnt;
    logic [BCW-1:0]           beat_cnt;
    logic [ADDR_WIDTH-1:0]    waddr_q;
    logic                     done_q;

    logic             last_beat, last_row, accept;
    logic             capture, start_run, start_empty, sel_load;
    logic [ROW_W-1:0] sel_row;
    logic [BCW-1:0]   sel_beat;

    assign last_beat = (beat_cnt == LAST_BEAT);
    assign last_row  = (row_cnt == num_rows_q - ROW_CNT_WIDTH'(1));
    assign accept    = (state == ST_DRAIN) && sram_ready;

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        capture     = 1'b0;
        start_run   = 1'b0;
        start_empty = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (cfg_num_rows != '0) begin
                        start_run = 1'b1;
                        state_nxt = ST_WAIT_ROW;
                    end else begin
                        start_empty = 1'b1;
                    end
                end
            end
            ST_WAIT_ROW: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept && last_beat) begin
                    if (last_row) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        // Accepting the next row here keeps back-to-back rows bubble-free.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT_ROW;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A fresh row is not in row_buf yet, so beat 0 comes straight from the input bus.
    always_comb begin
        sel_load = capture || (accept && !last_beat);
        sel_row  = capture ? parallel_data_in : row_buf;
        sel_beat = capture ? '0 : beat_cnt + BCW'(1);
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state      <= ST_IDLE;
            row_buf    <= '0;
            num_rows_q <= '0;
            row_cnt    <= '0;
            beat_cnt   <= '0;
            waddr_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= start_empty || (accept && last_beat && last_row);
            if (start_run) begin
                num_rows_q <= cfg_num_rows;
                waddr_q    <= cfg_base_addr;
                row_cnt    <= '0;
                beat_cnt   <= '0;
            end
            if (accept) begin
                waddr_q <= waddr_q + ADDR_WIDTH'(1);
                if (!last_beat) begin
                    beat_cnt <= beat_cnt + BCW'(1);
                end else if (!last_row) begin
                    row_cnt <= row_cnt + ROW_CNT_WIDTH'(1);
                end
            end
            if (capture) begin
                row_buf  <= parallel_data_in;
                beat_cnt <= '0;
            end
        end
    end

    write_out_beat_sel #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .BCW        (BCW)
    ) u_beat_sel (
        .clk   (clk),
        .srstn (srstn),
        .load  (sel_load),
        .row   (sel_row),
        .beat  (sel_beat),
        .wdata (sram_wdata)
    );

    assign sram_we    = (state == ST_DRAIN);
    assign sram_waddr = waddr_q;
    assign busy       = (state != ST_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_write_out_stream.sv
// Bench for write_out_stream: LANES=1 and LANES=4 instances checked against a beat-stream model.
module tb_write_out_stream;

    localparam int AS    = 32;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int RW    = 8;
    localparam int ROW_W = AS * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             srstn, cfg_start, in_valid, sram_ready, sel;
    logic [AW-1:0]    cfg_base_addr;
    logic [RW-1:0]    cfg_num_rows;
    logic [ROW_W-1:0] row_in;

    logic            a_in_ready, a_we, a_busy, a_done;
    logic [DW-1:0]   a_wdata;
    logic [AW-1:0]   a_waddr;
    logic            b_in_ready, b_we, b_busy, b_done;
    logic [4*DW-1:0] b_wdata;
    logic [AW-1:0]   b_waddr;

    logic         c_in_ready, c_we, c_busy, c_done;
    logic [127:0] c_wdata;
    logic [AW-1:0] c_waddr;

    write_out_stream #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .LANES(1), .ADDR_WIDTH(AW), .ROW_CNT_WIDTH(RW)) dut_a (
        .clk(clk), .srstn(srstn), .cfg_start(cfg_start & ~sel), .cfg_base_addr(cfg_base_addr),
        .cfg_num_rows(cfg_num_rows), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
        .parallel_data_in(row_in), .sram_ready(sram_ready), .sram_we(a_we), .sram_wdata(a_wdata),
        .sram_waddr(a_waddr), .busy(a_busy), .done(a_done));

    write_out_stream #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .LANES(4), .ADDR_WIDTH(AW), .ROW_CNT_WIDTH(RW)) dut_b (
        .clk(clk), .srstn(srstn), .cfg_start(cfg_start & sel), .cfg_base_addr(cfg_base_addr),
        .cfg_num_rows(cfg_num_rows), .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .parallel_data_in(row_in), .sram_ready(sram_ready), .sram_we(b_we), .sram_wdata(b_wdata),
        .sram_waddr(b_waddr), .busy(b_busy), .done(b_done));

    always_comb begin
        c_in_ready = sel ? b_in_ready : a_in_ready;
        c_we       = sel ? b_we       : a_we;
        c_busy     = sel ? b_busy     : a_busy;
        c_done     = sel ? b_done     : a_done;
        c_waddr    = sel ? b_waddr    : a_waddr;
        c_wdata    = sel ? b_wdata    : {96'b0, a_wdata};
    end

    int n_checks, n_fail;

    // Model: a run is the list of captured rows; beat k of the run goes to base+k.
    int lanes, beats;
    bit m_active, m_done_exp, after_rst, last_hs;
    int m_base, m_num, m_taken, m_done_beats, seq_k;
    logic [ROW_W-1:0] m_rows[$];
    logic [AW-1:0]    obs_addr[$];
    logic [127:0]     obs_data[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pend();
        return m_taken * beats - m_done_beats;
    endfunction

    function automatic logic [127:0] exp_data();
        int r, b;
        logic [ROW_W-1:0] row;
        logic [127:0] d;
        r = m_done_beats / beats;
        b = m_done_beats % beats;
        row = m_rows[r];
        d = '0;
        for (int j = 0; j < lanes; j++) d[j*DW +: DW] = row[(b*lanes + j)*DW +: DW];
        return d;
    endfunction

    function automatic logic [127:0] oa(input int i);
        if (i < obs_addr.size()) return 128'(obs_addr[i]);
        return '1;
    endfunction

    function automatic logic [127:0] od(input int i);
        if (i < obs_data.size()) return obs_data[i];
        return '1;
    endfunction

    task automatic tick();
        bit hs, acc, st, rs, exp_rdy;
        logic [ROW_W-1:0] row_s;
        logic [AW-1:0] base_s;
        logic [RW-1:0] num_s;
        @(negedge clk);
        rs = !srstn;
        exp_rdy = m_active && (pend() == 0 || (pend() == 1 && sram_ready && m_taken < m_num));
        if (!rs) chk("in_ready", 128'(c_in_ready), 128'(exp_rdy));
        hs = in_valid && exp_rdy;
        acc = (pend() > 0) && sram_ready;
        st = cfg_start;
        row_s = row_in;
        base_s = cfg_base_addr;
        num_s = cfg_num_rows;
        if (c_we === 1'b1 && sram_ready) begin
            obs_addr.push_back(c_waddr);
            obs_data.push_back(c_wdata);
        end
        last_hs = hs;
        @(posedge clk);
        #1;
        m_done_exp = 1'b0;
        after_rst = 1'b0;
        if (rs) begin
            m_active = 1'b0; m_taken = 0; m_done_beats = 0; m_rows.delete(); after_rst = 1'b1;
        end else if (!m_active) begin
            if (st) begin
                if (num_s == '0) begin
                    m_done_exp = 1'b1;
                end else begin
                    m_active = 1'b1; m_base = int'(base_s); m_num = int'(num_s);
                    m_taken = 0; m_done_beats = 0; m_rows.delete();
                end
            end
        end else begin
            if (hs) begin
                m_rows.push_back(row_s);
                m_taken++;
            end
            if (acc) begin
                m_done_beats++;
                if (m_done_beats == m_num * beats) begin
                    m_active = 1'b0;
                    m_done_exp = 1'b1;
                end
            end
        end
        chk("busy", 128'(c_busy), 128'(m_active));
        chk("done", 128'(c_done), 128'(m_done_exp));
        chk("sram_we", 128'(c_we), 128'(pend() > 0));
        if (pend() > 0) begin
            chk("waddr", 128'(c_waddr), 128'((m_base + m_done_beats) % (1 << AW)));
            chk("wdata", c_wdata, exp_data());
        end
        if (after_rst) begin
            chk("rst_waddr", 128'(c_waddr), 128'(0));
            chk("rst_wdata", c_wdata, 128'(0));
        end
    endtask

    task automatic new_row(input bit seq);
        for (int i = 0; i < AS; i++) begin
            if (seq) row_in[i*DW +: DW] = DW'(seq_k * 256 + i);
            else     row_in[i*DW +: DW] = $urandom;
        end
        seq_k++;
    endtask

    task automatic run(input int base, input int rows, input bit seq, input int rdy_pct,
                       input int vld_pct, input int stall_beat, input int gap_row,
                       input int rst_beat, input bit busy_start, output int cycles);
        int wait_cnt, stall_left;
        bit stalled, rst_done;
        wait_cnt = 0; stall_left = 0; stalled = 1'b0; rst_done = 1'b0;
        seq_k = 0;
        obs_addr.delete();
        obs_data.delete();
        cycles = 0;
        new_row(seq);
        cfg_base_addr = AW'(base);
        cfg_num_rows = RW'(rows);
        cfg_start = 1'b1;
        in_valid = 1'b0;
        sram_ready = 1'b1;
        tick();
        cfg_start = 1'b0;
        if (rows == 0) chk("zero_rows_done", 128'(c_done), 128'(1));
        while (m_active && cycles < 4000) begin
            if (last_hs) new_row(seq);
            if (!(in_valid && !last_hs)) begin
                if (m_taken >= m_num) begin
                    in_valid = 1'b0;
                end else if (m_taken == gap_row && wait_cnt < 4) begin
                    in_valid = 1'b0;
                    if (pend() == 0) wait_cnt++;
                end else begin
                    in_valid = ($urandom_range(99) < vld_pct);
                end
            end
            if (stall_beat >= 0 && !stalled && m_done_beats == stall_beat && pend() > 0) begin
                stalled = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                sram_ready = 1'b0;
                stall_left--;
            end else begin
                sram_ready = ($urandom_range(99) < rdy_pct);
            end
            if (busy_start && cycles == 5) begin
                cfg_start = 1'b1;
                cfg_base_addr = AW'(base + 'h55);
                cfg_num_rows = RW'(rows + 5);
            end else begin
                cfg_start = 1'b0;
            end
            srstn = !(rst_beat >= 0 && !rst_done && m_done_beats == rst_beat && pend() > 0);
            if (!srstn) rst_done = 1'b1;
            tick();
            cycles++;
            srstn = 1'b1;
        end
        chk("run_timeout", 128'(cycles >= 4000), 128'(0));
        cfg_start = 1'b0;
        sram_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        int cyc;
        n_checks = 0; n_fail = 0;
        sel = 1'b0; lanes = 1; beats = 32;
        srstn = 1'b0; cfg_start = 1'b0; in_valid = 1'b0; sram_ready = 1'b1;
        cfg_base_addr = '0; cfg_num_rows = '0; row_in = '0;
        m_active = 1'b0; m_done_exp = 1'b0; after_rst = 1'b0; last_hs = 1'b0;
        m_base = 0; m_num = 0; m_taken = 0; m_done_beats = 0; seq_k = 0;
        tick();
        tick();
        srstn = 1'b1;
        tick();

        // LANES=1: single row, sequential words
        run('h010, 1, 1'b1, 100, 100, -1, -1, -1, 1'b0, cyc);
        chk("s1_cycles", 128'(cyc), 128'(33));
        chk("s1_writes", 128'(obs_addr.size()), 128'(32));
        chk("s1_addr_first", oa(0), 128'h010);
        chk("s1_addr_last", oa(31), 128'h02F);
        chk("s1_data_first", od(0), 128'd0);
        chk("s1_data_last", od(31), 128'd31);

        // SRAM backpressure for 5 cycles at beat 7
        run('h080, 1, 1'b1, 100, 100, 7, -1, -1, 1'b0, cyc);
        chk("stall_cycles", 128'(cyc), 128'(38));
        chk("stall_writes", 128'(obs_addr.size()), 128'(32));
        chk("stall_addr7", oa(7), 128'h087);
        chk("stall_addr8", oa(8), 128'h088);
        chk("stall_data8", od(8), 128'd8);

        // Three rows, row 2 arrives late
        run('h040, 3, 1'b1, 100, 100, -1, 2, -1, 1'b0, cyc);
        chk("gap_cycles", 128'(cyc), 128'(102));
        chk("gap_writes", 128'(obs_addr.size()), 128'(96));
        chk("gap_row2_addr", oa(64), 128'h080);
        chk("gap_row2_data", od(64), 128'h200);

        // Zero rows: done only
        run('h123, 0, 1'b1, 100, 100, -1, -1, -1, 1'b0, cyc);
        chk("zero_writes", 128'(obs_addr.size()), 128'(0));

        // cfg_start while busy is ignored
        run('h300, 2, 1'b1, 100, 100, -1, -1, -1, 1'b1, cyc);
        chk("busy_start_writes", 128'(obs_addr.size()), 128'(64));
        chk("busy_start_last", oa(63), 128'h33F);

        // Reset mid-drain, then a clean restart from a new base
        run('h020, 1, 1'b1, 100, 100, -1, -1, 10, 1'b0, cyc);
        run('h100, 1, 1'b1, 100, 100, -1, -1, -1, 1'b0, cyc);
        chk("restart_addr", oa(0), 128'h100);
        chk("restart_writes", 128'(obs_addr.size()), 128'(32));

        for (int k = 0; k < 3; k++)
            run(int'($urandom_range(1023)), int'($urandom_range(4, 1)), 1'b0, 70, 60, -1, -1, -1, 1'b0, cyc);

        // LANES=4 instance
        sel = 1'b1; lanes = 4; beats = 8;
        tick();
        run('h3FC, 2, 1'b1, 100, 100, -1, -1, -1, 1'b0, cyc);
        chk("l4_cycles", 128'(cyc), 128'(17));
        chk("l4_writes", 128'(obs_addr.size()), 128'(16));
        chk("l4_addr_first", oa(0), 128'h3FC);
        chk("l4_addr_wrap", oa(4), 128'h000);
        chk("l4_addr_last", oa(15), 128'h00B);
        chk("l4_data_b5", od(5), 128'h00000017_00000016_00000015_00000014);
        chk("l4_data_b9", od(9), 128'h00000107_00000106_00000105_00000104);

        run('h200, 3, 1'b1, 100, 100, 3, -1, -1, 1'b0, cyc);
        chk("l4_stall_writes", 128'(obs_addr.size()), 128'(24));

        for (int k = 0; k < 3; k++)
            run(int'($urandom_range(1023)), int'($urandom_range(4, 1)), 1'b0, 70, 60, -1, -1, -1, 1'b0, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_out_stream.md
Name: write_out_stream

Overview:
- Parametrised successor of the single-row result serializer.
- Accepts a sequence of wide PE result rows over a valid/ready handshake and buffers one row.
- Drains each row to the output SRAM as LANES words per beat, auto-incrementing the address from a programmable base; honours SRAM backpressure.
- Signals completion after a programmed number of rows. Sits between the PE array output bus and the result SRAM, controlled by the top-level sequencer.

Parameters:
- ARRAY_SIZE, 32, words per PE result row.
- DATA_WIDTH, 32, bits per word (single-precision float).
- LANES, 1, words written per SRAM beat; must divide ARRAY_SIZE.
- ADDR_WIDTH, 10, SRAM word-group address width.
- ROW_CNT_WIDTH, 8, width of the programmed row count.
- Derived: BEATS = ARRAY_SIZE/LANES.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- srstn, input, 1, synchronous active-low reset.
- cfg_start, input, 1, one-cycle start pulse; sampled only in IDLE.
- cfg_base_addr, input, ADDR_WIDTH, first SRAM address; latched on cfg_start.
- cfg_num_rows, input, ROW_CNT_WIDTH, rows to write; latched on cfg_start.
- in_valid, input, 1, parallel_data_in holds a valid row.
- in_ready, output, 1, row accepted when in_valid & in_ready.
- parallel_data_in, input, ARRAY_SIZE*DATA_WIDTH, row; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- sram_ready, input, 1, SRAM accepts the current beat.
- sram_we, output, 1, beat valid.
- sram_wdata, output, LANES*DATA_WIDTH, beat data; lane j = row word beat*LANES+j.
- sram_waddr, output, ADDR_WIDTH, beat address.
- busy, output, 1, high outside IDLE.
- done, output, 1, one-cycle pulse after the last beat of the last row is accepted.

Behaviour:
- Reset (srstn low at a clock edge): state IDLE; sram_we=0, sram_wdata=0, sram_waddr=0, done=0, busy=0, in_ready=0. All counters and the row buffer are cleared. Reset mid-drain discards the buffered row and the remaining beats; no further writes.
- States: IDLE, WAIT_ROW, DRAIN.
- IDLE:
  - cfg_start with cfg_num_rows>0: latch base and count, zero the row and beat counters, go to WAIT_ROW.
  - cfg_start with cfg_num_rows==0: stay in IDLE; done pulses the next cycle.
- WAIT_ROW: in_ready=1. On in_valid, capture the row into the buffer and go to DRAIN. Next cycle: sram_we=1, beat 0 data, sram_waddr = base + row*BEATS. Latency from capture to first sram_we is one cycle.
- DRAIN:
  - sram_we=1. A beat is accepted when sram_ready=1.
  - On acceptance the registered outputs advance to the next beat: waddr+1, next lane slice.
  - While sram_ready=0, sram_we, sram_wdata and sram_waddr hold stable.
- Last beat of a row accepted:
  - Last row: go to IDLE; sram_we=0 next cycle; done=1 for one cycle.
  - Otherwise, in_ready is asserted combinationally in that same cycle (in_ready = last beat & sram_ready & not last row). If in_valid, capture the new row and stay in DRAIN with beat 0 next cycle (back-to-back, no bubble). Otherwise go to WAIT_ROW.
- in_ready is 0 in IDLE and in DRAIN except for the last-beat case above.
- Addresses are contiguous across rows and wrap modulo 2^ADDR_WIDTH with no error.
- cfg_start outside IDLE is ignored.
- in_valid in IDLE is not accepted.
- Throughput: with sram_ready tied high, one beat per cycle and BEATS cycles per row.

Decomposition:
- Shared package (write_out_pkg): state enum, BEATS and BEAT_CNT_WIDTH localparam functions, and a static check that LANES divides ARRAY_SIZE.
- One natural sub-module: write_out_beat_sel, a registered lane-slice mux that selects LANES words from the row buffer by beat index.

Test Plan:
- Defaults, base=0x010, rows=1, sram_ready=1, row words = 0..31 -> 32 writes at addr 0x010..0x02F with data 0..31; done exactly one cycle after the last beat.
- LANES=4, rows=2, base=0x3FC, back-to-back in_valid -> 16 beats, no bubble between rows; addresses 0x3FC..0x3FF then wrap to 0x000..0x00B; lane j of beat b = word 4b+j.
- sram_ready held low for 5 cycles at beat 7 -> sram_we/waddr/wdata stable for those 5 cycles, no beat skipped or duplicated, total 32 accepted writes.
- rows=3 with in_valid delayed 4 cycles before row 2 -> WAIT_ROW entered, sram_we=0 during the gap, row 2 resumes at base+64.
- cfg_num_rows=0 -> no writes, done pulses next cycle; cfg_start while busy -> ignored, programmed count unchanged.
- srstn low at beat 10 of row 0 -> next cycle all outputs 0 and state IDLE; a new cfg_start restarts from the new base.
